// File: rtl/usart_rx_fifo.sv
// usart_rx_fifo: receive FIFO behind usart_rx with a one-cycle acknowledge and a first-word-fall-through read side.
// Ports:
//   comm_clock, reset          clock; asynchronous active-high reset
//   in_data/in_valid/in_error  byte, valid and frame-error flag from usart_rx
//   in_ready                   one-cycle acknowledge pulse for each accepted byte
//   out_data/out_error         head entry; zero while the FIFO is empty
//   out_valid/out_ready        FIFO non-empty / consumer pop request
//   flush                      synchronous discard of all entries
//   count, almost_full         registered occupancy and high-water flag
//   err_count                  saturating count of error entries written
module usart_rx_fifo #(
    parameter int DEPTH     = 16,
    parameter int ADDR_BITS = 4,
    parameter int AF_MARGIN = 4
) (
    input  logic                 comm_clock,
    input  logic                 reset,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    input  logic                 in_error,
    output logic                 in_ready,
    output logic [7:0]           out_data,
    output logic                 out_error,
    output logic                 out_valid,
    input  logic                 out_ready,
    input  logic                 flush,
    output logic [ADDR_BITS:0]   count,
    output logic                 almost_full,
    output logic [7:0]           err_count
);
    typedef enum logic [1:0] {IDLE, ACK, WAIT_LOW} state_t;

    state_t                 state_q, state_d;
    logic [ADDR_BITS-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_BITS:0]     count_q, count_d;
    logic                   in_ready_q, in_ready_d;
    logic                   af_q, af_d;
    logic [7:0]             err_q, err_d;
    logic [8:0]             mem_q [DEPTH];
    logic [8:0]             head;
    logic                   full, push, pop;

    assign out_valid   = count_q != '0;
    assign head        = mem_q[rd_ptr_q];
    assign out_data    = out_valid ? head[7:0] : 8'h00;
    assign out_error   = out_valid & head[8];
    assign in_ready    = in_ready_q;
    assign count       = count_q;
    assign almost_full = af_q;
    assign err_count   = err_q;

    always_comb begin
        // Full uses the pre-edge count, so a same-cycle pop never frees room for a push.
        full       = count_q == (ADDR_BITS+1)'(DEPTH);
        push       = (state_q == IDLE) && in_valid && !full && !flush;
        pop        = out_valid && out_ready && !flush;
        state_d    = state_q;
        in_ready_d = 1'b0;
        case (state_q)
            IDLE: begin
                state_d    = push ? ACK : IDLE;
                in_ready_d = push;
            end
            ACK:      state_d = WAIT_LOW;
            // Waiting for valid to drop keeps a held byte from being written twice.
            WAIT_LOW: state_d = in_valid ? WAIT_LOW : IDLE;
            default:  state_d = IDLE;
        endcase
        wr_ptr_d = flush ? '0 : wr_ptr_q + ADDR_BITS'(push);
        rd_ptr_d = flush ? '0 : rd_ptr_q + ADDR_BITS'(pop);
        count_d  = flush ? '0 : count_q + (ADDR_BITS+1)'(push) - (ADDR_BITS+1)'(pop);
        af_d     = count_d >= (ADDR_BITS+1)'(DEPTH - AF_MARGIN);
        err_d    = err_q + 8'(push && in_error && (err_q != 8'hff));
    end

    always_ff @(posedge comm_clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b0;
            af_q       <= 1'b0;
            err_q      <= 8'h00;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
            af_q       <= af_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge comm_clock) begin
        if (push)
            mem_q[wr_ptr_q] <= {in_error, in_data};
    end
endmodule

// File: tb/tb_usart_rx_fifo.sv
// tb_usart_rx_fifo: directed scenarios plus randomized traffic against a queue-based model of usart_rx_fifo.
module tb_usart_rx_fifo;
    logic       comm_clock = 1'b0;
    logic       reset, in_valid, in_error, out_ready, flush;
    logic [7:0] in_data;
    logic       in_ready, out_error, out_valid, almost_full;
    logic [7:0] out_data, err_count;
    logic [4:0] count;

    int         n_chk = 0;
    int         n_fail = 0;
    logic [8:0] q[$];
    int         m_err;
    int         m_ph;
    bit         m_rdy;

    usart_rx_fifo dut (
        .comm_clock (comm_clock),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_error   (in_error),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_error  (out_error),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .flush      (flush),
        .count      (count),
        .almost_full(almost_full),
        .err_count  (err_count)
    );

    always #5 comm_clock = ~comm_clock;

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_err = 0;
        m_ph  = 0;
        m_rdy = 0;
    endtask

    task automatic check_all();
        logic [8:0] h;
        h = (q.size() != 0) ? q[0] : 9'h000;
        chk("in_ready", in_ready, m_rdy);
        chk("out_valid", out_valid, q.size() != 0);
        chk("count", count, q.size());
        chk("almost_full", almost_full, q.size() >= 12);
        chk("err_count", err_count, m_err);
        chk("out_data", out_data, h[7:0]);
        chk("out_error", out_error, h[8]);
    endtask

    // m_ph: 0 ready for a byte, 1 acknowledging, 2 waiting for valid to drop.
    task automatic cyc();
        bit push, pop;
        pop  = (q.size() != 0) && out_ready && !flush;
        push = (m_ph == 0) && in_valid && (q.size() < 16) && !flush;
        if (flush) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back({in_error, in_data});
        end
        if (push && in_error && m_err < 255) m_err++;
        m_ph  = push ? 1 : (m_ph == 1) ? 2 : (m_ph == 2 && !in_valid) ? 0 : m_ph;
        m_rdy = push;
        @(posedge comm_clock);
        #1;
        check_all();
    endtask

    task automatic put(input logic [7:0] d, input logic e);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_error = e;
        do begin
            cyc();
            n++;
        end while (!in_ready && n < 40);
        chk("put_ack", in_ready, 1'b1);
        in_valid = 1'b0;
        cyc();
        cyc();
    endtask

    initial begin
        int pulses, pr, hold, low, wt;
        bit acked;
        logic [7:0] exp5 [3];
        reset = 1'b1; in_valid = 0; in_error = 0; in_data = 0; out_ready = 0; flush = 0;
        model_reset();
        #20;
        check_all();
        @(negedge comm_clock);
        reset = 1'b0;

        in_valid = 1'b1; in_data = 8'h75; in_error = 1'b0;
        pulses = 0;
        repeat (10) begin
            cyc();
            pulses += int'(in_ready);
        end
        chk("t2_pulses", pulses, 1);
        in_valid = 1'b0;
        cyc();
        cyc();
        chk("t2_count", count, 1);
        chk("t2_data", out_data, 8'h75);

        put(8'hF5, 1'b1);
        chk("t3_err_count", err_count, 1);
        out_ready = 1'b1;
        chk("t3_first", out_data, 8'h75);
        cyc();
        chk("t3_second", out_data, 8'hF5);
        chk("t3_second_err", out_error, 1'b1);
        cyc();
        out_ready = 1'b0;
        chk("t3_empty", out_valid, 1'b0);

        for (int i = 0; i < 16; i++) put(8'(i), 1'b0);
        chk("t4_count", count, 16);
        chk("t4_af", almost_full, 1'b1);
        in_valid = 1'b1; in_data = 8'h10; in_error = 1'b0;
        repeat (4) begin
            cyc();
            chk("t4_backpressure", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        chk("t4_head", out_data, 8'h00);
        cyc();
        out_ready = 1'b0;
        chk("t4_no_push_on_pop", in_ready, 1'b0);
        cyc();
        chk("t4_accept", in_ready, 1'b1);
        in_valid = 1'b0;
        cyc();
        cyc();
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            chk("t4_drain", out_data, i);
            cyc();
        end
        out_ready = 1'b0;
        chk("t4_empty", out_valid, 1'b0);

        put(8'h31, 1'b0);
        put(8'h32, 1'b0);
        put(8'h33, 1'b0);
        in_valid = 1'b1; in_data = 8'h42; in_error = 1'b0; out_ready = 1'b1;
        cyc();
        chk("t5_push", in_ready, 1'b1);
        chk("t5_count", count, 3);
        out_ready = 1'b0; in_valid = 1'b0;
        cyc();
        cyc();
        exp5[0] = 8'h32; exp5[1] = 8'h33; exp5[2] = 8'h42;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("t5_order", out_data, exp5[i]);
            cyc();
        end
        out_ready = 1'b0;

        for (int i = 0; i < 5; i++) put(8'h50 + 8'(i), 1'b0);
        chk("t6_pre_count", count, 5);
        in_valid = 1'b1; in_data = 8'h66; flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("t6_flush_count", count, 0);
        chk("t6_flush_valid", out_valid, 1'b0);
        chk("t6_flush_ready", in_ready, 1'b0);
        cyc();
        chk("t6_accept", in_ready, 1'b1);
        chk("t6_count", count, 1);
        chk("t6_err_kept", err_count, 1);
        in_valid = 1'b0;
        cyc();
        cyc();

        in_valid = 1'b1; in_data = 8'h99; in_error = 1'b1;
        cyc();
        chk("rst_pre_ack", in_ready, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_ready_drop", in_ready, 1'b0);
        chk("rst_count", count, 0);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_err", err_count, 0);
        model_reset();
        in_valid = 1'b0; in_error = 1'b0;
        @(negedge comm_clock);
        reset = 1'b0;

        pr = 50; hold = 0; low = 2; wt = 0; acked = 0;
        for (int c = 0; c < 4000; c++) begin
            if (c % 250 == 0) pr = ($urandom_range(0, 2) == 0) ? 25 : ($urandom_range(0, 1) == 0) ? 50 : 90;
            out_ready = $urandom_range(0, 99) < pr;
            flush     = $urandom_range(0, 149) == 0;
            if (!in_valid && low == 0) begin
                in_valid = 1'b1;
                in_data  = 8'($urandom);
                in_error = $urandom_range(0, 9) < 6;
                wt       = 0;
            end
            cyc();
            if (!in_valid) begin
                if (low > 0) low--;
            end else if (!acked) begin
                if (in_ready) begin
                    acked = 1;
                    hold  = $urandom_range(0, 2);
                end else if (++wt > 400) begin
                    chk("drv_stall", in_ready, 1'b1);
                    in_valid = 1'b0;
                    low      = 2;
                end
            end else if (hold == 0) begin
                in_valid = 1'b0;
                acked    = 0;
                low      = $urandom_range(2, 4);
            end else begin
                hold--;
            end
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        cyc();
        cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
